sh7604_divu_sched: RTL and testbench
====================================

// Module: sh7604_divu_sched
// PURPOSE
//  Two-port job scheduler/arbiter for the SH7604 DIVU register interface. Accepts 32/64-bit
//  signed divide jobs from two requesters, round-robin arbitrates, drives DIVU register
//  writes as an internal-bus master, waits out the divide, reads quotient/remainder/OVF
//  back, clears OVF, and returns results. Sits between DIVU users and the DIVU IBUS slave port.
// PARAMETERS
//  BASE_ADDR  32'hFFFFFF00  DIVU register base (DVSR+0x00, DVDNT+0x04, DVCR+0x08, DVDNTH+0x10, DVDNTL+0x14)
//  CLR_OVF    1             1: write DVCR=0 after a job that returned OVF=1; 0: leave DVCR untouched
// PORTS
//  CLK        in   1   clock
//  RST        in   1   synchronous active-high reset
//  CE_R       in   1   clock enable; all state/bus updates occur only on CLK edges with CE_R=1
//  R0_REQ     in   1   requester 0 job request (level, held until R0_ACK)
//  R0_DIV64   in   1   1: 64/32 divide (DVDNTH:DVDNTL / DVSR); 0: 32/32 (DVDNTL / DVSR)
//  R0_DVSR    in   32  divisor
//  R0_DVDNTH  in   32  dividend high (ignored when R0_DIV64=0)
//  R0_DVDNTL  in   32  dividend low
//  R0_ACK     out  1   one-cycle pulse: job done, RES_* valid this cycle
//  R1_*       --   --  identical set for requester 1
//  RES_Q      out  32  quotient (DVDNTL readback)
//  RES_R      out  32  remainder (DVDNTH readback)
//  RES_OVF    out  1   DVCR.OVF (bit 0) readback
//  RES_ID     out  1   requester that owns RES_* (0/1)
//  M_A        out  32  bus address to DIVU
//  M_DO       out  32  write data to DIVU
//  M_DI       in   32  read data from DIVU
//  M_BA       out  4   byte enables; always 4'hF
//  M_WE       out  1   1=write, 0=read
//  M_REQ      out  1   bus request
//  M_BUSY     in   1   DIVU busy; access completes on CE_R edge with M_REQ=1 && M_BUSY=0
//  BUSY       out  1   scheduler not IDLE
// BEHAVIOUR
//  Reset: state IDLE, M_REQ=0, M_WE=0, M_A=BASE_ADDR, M_DO=0, M_BA=4'hF, R0/R1_ACK=0, RES_*=0,
//   round-robin pointer=0 (R0 preferred). RST mid-job: abort immediately, M_REQ=0 next cycle,
//   no ACK issued; DIVU state is not cleaned up (next job overwrites all operands).
//  Arbitration (IDLE only): if both REQ, grant pointer side, then pointer <= ~granted;
//   single REQ granted regardless of pointer (pointer <= ~granted). Operands latched at grant;
//   later changes to R*_ inputs ignored. Dropping REQ before grant is legal; after grant the job
//   always completes and ACKs.
//  FSM (each bus state holds M_REQ/M_A/M_WE/M_DO stable until completion, then advances):
//   IDLE -> WR_DVSR (A=+0x00, DO=DVSR)
//   WR_DVSR -> DIV64 ? WR_DVDNTH (A=+0x10, DO=DVDNTH) : WR_DVDNT (A=+0x04, DO=DVDNTL; starts 32-bit)
//   WR_DVDNTH -> WR_DVDNTL (A=+0x14, DO=DVDNTL; starts 64-bit)
//   WR_DVDNT/WR_DVDNTL -> RD_DVCR (A=+0x08 read; stalls via M_BUSY until divide done; latch OVF=M_DI[0])
//   RD_DVCR -> RD_Q (A=+0x14 read; latch RES_Q) -> RD_R (A=+0x10 read; latch RES_R)
//   RD_R -> (CLR_OVF && OVF) ? WR_DVCR (A=+0x08, DO=0) : DONE;  WR_DVCR -> DONE
//   DONE: R<ID>_ACK=1 for exactly one CE_R cycle, M_REQ=0, -> IDLE. RES_* hold until next latch.
//  Read data sampled on the completing CE_R edge. M_REQ deasserts for >=1 cycle only in IDLE/DONE.
//  New grant possible on the CE_R edge after DONE (min 2 cycles between jobs' first accesses of DONE->IDLE->WR).
//  CE_R=0: all state, outputs and ACK frozen (ACK pulse extends until the next CE_R edge).
//  No arithmetic in this block; signedness/overflow saturation is the DIVU's (OVFIE kept 0 via WR_DVCR=0).
//  Latency (no stalls, 32-bit, no OVF): grant->ACK = 6 CE_R cycles + DIVU stall in RD_DVCR.
// TESTING
//  32-bit: R0 DVSR=7, DVDNTL=100 -> writes +00=7, +04=100; RES_Q=14, RES_R=2, RES_OVF=0, R0_ACK once, RES_ID=0.
//  64-bit: R1 DVSR=0x10, DVDNTH=1, DVDNTL=0 -> writes +00,+10,+14 in order; RES_Q=0x10000000, RES_R=0, RES_ID=1.
//  Div-by-zero: DVSR=0, DVDNTL=5 -> RES_OVF=1, RES_Q=0x7FFFFFFF; WR_DVCR of 0 issued (absent if CLR_OVF=0).
//  R0/R1 REQ both held for 4 jobs -> grants alternate R0,R1,R0,R1; each ACK pairs with its own RES_ID.
//  M_BUSY held high 10 cycles in WR_DVSR and RD_DVCR -> M_A/M_DO/M_WE stable throughout, no skipped access.
//  RST pulsed in RD_Q -> next cycle M_REQ=0, no ACK, pointer=0; following R1 job completes correctly.

Source files
------------

// File: rtl/sh7604_divu_sched.sv
// Two-port round-robin job scheduler driving the SH7604 DIVU register file as a bus master.
// Writes operands, waits out the divide on the DVCR read, reads results back and acks the owner.
module sh7604_divu_sched #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00,
  parameter bit          CLR_OVF   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        R0_REQ,
  input  logic        R0_DIV64,
  input  logic [31:0] R0_DVSR,
  input  logic [31:0] R0_DVDNTH,
  input  logic [31:0] R0_DVDNTL,
  output logic        R0_ACK,
  input  logic        R1_REQ,
  input  logic        R1_DIV64,
  input  logic [31:0] R1_DVSR,
  input  logic [31:0] R1_DVDNTH,
  input  logic [31:0] R1_DVDNTL,
  output logic        R1_ACK,
  output logic [31:0] RES_Q,
  output logic [31:0] RES_R,
  output logic        RES_OVF,
  output logic        RES_ID,
  output logic [31:0] M_A,
  output logic [31:0] M_DO,
  input  logic [31:0] M_DI,
  output logic [3:0]  M_BA,
  output logic        M_WE,
  output logic        M_REQ,
  input  logic        M_BUSY,
  output logic        BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DVSR, S_WR_DVDNTH, S_WR_DVDNT, S_WR_DVDNTL,
    S_RD_DVCR, S_RD_Q, S_RD_R, S_WR_DVCR, S_DONE
  } state_t;

  localparam logic [31:0] A_DVSR   = BASE_ADDR + 32'h00;
  localparam logic [31:0] A_DVDNT  = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_DVCR   = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_DVDNTH = BASE_ADDR + 32'h10;
  localparam logic [31:0] A_DVDNTL = BASE_ADDR + 32'h14;

  state_t      state_reg;
  logic        ptr_reg;
  logic        id_reg;
  logic        div64_reg;
  logic [31:0] dvdnth_reg;
  logic [31:0] dvdntl_reg;
  logic        grant_id;
  logic        xfer_done;

  // Contention goes to the pointer side; a lone requester wins regardless of the pointer.
  always_comb begin
    grant_id = R1_REQ;
    if (R0_REQ && R1_REQ) grant_id = ptr_reg;
  end

  assign xfer_done = M_REQ && !M_BUSY;
  assign M_BA      = 4'hF;
  assign BUSY      = (state_reg != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= 1'b0;
      id_reg     <= 1'b0;
      div64_reg  <= 1'b0;
      dvdnth_reg <= '0;
      dvdntl_reg <= '0;
      M_REQ      <= 1'b0;
      M_WE       <= 1'b0;
      M_A        <= BASE_ADDR;
      M_DO       <= '0;
      R0_ACK     <= 1'b0;
      R1_ACK     <= 1'b0;
      RES_Q      <= '0;
      RES_R      <= '0;
      RES_OVF    <= 1'b0;
      RES_ID     <= 1'b0;
    end else if (CE_R) begin
      R0_ACK <= 1'b0;
      R1_ACK <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (R0_REQ || R1_REQ) begin
            id_reg     <= grant_id;
            ptr_reg    <= ~grant_id;
            div64_reg  <= grant_id ? R1_DIV64  : R0_DIV64;
            dvdnth_reg <= grant_id ? R1_DVDNTH : R0_DVDNTH;
            dvdntl_reg <= grant_id ? R1_DVDNTL : R0_DVDNTL;
            M_DO       <= grant_id ? R1_DVSR   : R0_DVSR;
            M_A        <= A_DVSR;
            M_WE       <= 1'b1;
            M_REQ      <= 1'b1;
            state_reg  <= S_WR_DVSR;
          end
        end
        S_WR_DVSR: if (xfer_done) begin
          if (div64_reg) begin
            M_A       <= A_DVDNTH;
            M_DO      <= dvdnth_reg;
            state_reg <= S_WR_DVDNTH;
          end else begin
            M_A       <= A_DVDNT;
            M_DO      <= dvdntl_reg;
            state_reg <= S_WR_DVDNT;
          end
        end
        S_WR_DVDNTH: if (xfer_done) begin
          M_A       <= A_DVDNTL;
          M_DO      <= dvdntl_reg;
          state_reg <= S_WR_DVDNTL;
        end
        S_WR_DVDNT, S_WR_DVDNTL: if (xfer_done) begin
          M_A       <= A_DVCR;
          M_WE      <= 1'b0;
          state_reg <= S_RD_DVCR;
        end
        // The DIVU holds M_BUSY here until the divide has finished.
        S_RD_DVCR: if (xfer_done) begin
          RES_OVF   <= M_DI[0];
          RES_ID    <= id_reg;
          M_A       <= A_DVDNTL;
          state_reg <= S_RD_Q;
        end
        S_RD_Q: if (xfer_done) begin
          RES_Q     <= M_DI;
          M_A       <= A_DVDNTH;
          state_reg <= S_RD_R;
        end
        S_RD_R: if (xfer_done) begin
          RES_R <= M_DI;
          if (CLR_OVF && RES_OVF) begin
            M_A       <= A_DVCR;
            M_DO      <= '0;
            M_WE      <= 1'b1;
            state_reg <= S_WR_DVCR;
          end else begin
            M_REQ     <= 1'b0;
            R0_ACK    <= ~id_reg;
            R1_ACK    <= id_reg;
            state_reg <= S_DONE;
          end
        end
        S_WR_DVCR: if (xfer_done) begin
          M_REQ     <= 1'b0;
          M_WE      <= 1'b0;
          R0_ACK    <= ~id_reg;
          R1_ACK    <= id_reg;
          state_reg <= S_DONE;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sh7604_divu_sched.sv
// Directed bench for sh7604_divu_sched with a small behavioural DIVU slave on the bus side.
// Covers 32/64-bit jobs, divide-by-zero with OVF clear, arbitration, bus stalls, CE_R and mid-job reset.
module tb_sh7604_divu_sched;
  localparam logic [31:0] BASE = 32'hFFFFFF00;

  logic        CLK = 1'b0, RST = 1'b1, CE_R = 1'b1;
  logic        R0_REQ = 0, R0_DIV64 = 0, R1_REQ = 0, R1_DIV64 = 0;
  logic [31:0] R0_DVSR = 0, R0_DVDNTH = 0, R0_DVDNTL = 0;
  logic [31:0] R1_DVSR = 0, R1_DVDNTH = 0, R1_DVDNTL = 0;
  logic        R0_ACK, R1_ACK, RES_OVF, RES_ID, M_WE, M_REQ, BUSY;
  logic [31:0] RES_Q, RES_R, M_A, M_DO, M_DI;
  logic [3:0]  M_BA;
  logic        M_BUSY;

  sh7604_divu_sched dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R),
    .R0_REQ(R0_REQ), .R0_DIV64(R0_DIV64), .R0_DVSR(R0_DVSR), .R0_DVDNTH(R0_DVDNTH),
    .R0_DVDNTL(R0_DVDNTL), .R0_ACK(R0_ACK),
    .R1_REQ(R1_REQ), .R1_DIV64(R1_DIV64), .R1_DVSR(R1_DVSR), .R1_DVDNTH(R1_DVDNTH),
    .R1_DVDNTL(R1_DVDNTL), .R1_ACK(R1_ACK),
    .RES_Q(RES_Q), .RES_R(RES_R), .RES_OVF(RES_OVF), .RES_ID(RES_ID),
    .M_A(M_A), .M_DO(M_DO), .M_DI(M_DI), .M_BA(M_BA), .M_WE(M_WE),
    .M_REQ(M_REQ), .M_BUSY(M_BUSY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // DIVU slave model
  logic [31:0] s_dvsr = 0, s_dvdnth = 0, s_dvdntl = 0, s_dvcr = 0;
  int          stall_cnt = 0;
  logic        busy_force = 0;
  logic [7:0]  log_off [0:63];
  logic        log_we  [0:63];
  logic [31:0] log_d   [0:63];
  int          log_n = 0;
  int          ack0_cnt = 0, ack1_cnt = 0;
  logic [7:0]  off;

  assign off    = 8'(M_A - BASE);
  assign M_BUSY = busy_force || (stall_cnt != 0);

  always_comb begin
    case (off)
      8'h00:   M_DI = s_dvsr;
      8'h04:   M_DI = s_dvdntl;
      8'h08:   M_DI = s_dvcr;
      8'h10:   M_DI = s_dvdnth;
      8'h14:   M_DI = s_dvdntl;
      default: M_DI = 32'h0;
    endcase
  end

  function automatic logic [64:0] divide(input logic [63:0] dnd, input logic [31:0] dvs);
    longint a, b, q, r;
    if (dvs == 32'h0) return {1'b1, dnd[31:0], (dnd[63] ? 32'h80000000 : 32'h7FFFFFFF)};
    a = longint'(dnd);
    b = longint'($signed(dvs));
    q = a / b;
    r = a % b;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  always @(posedge CLK) begin : slave
    logic [64:0] res_v;
    if (CE_R) begin
      if (R0_ACK) ack0_cnt <= ack0_cnt + 1;
      if (R1_ACK) ack1_cnt <= ack1_cnt + 1;
      if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
      if (M_REQ && !M_BUSY) begin
        log_off[log_n[5:0]] <= off;
        log_we[log_n[5:0]]  <= M_WE;
        log_d[log_n[5:0]]   <= M_WE ? M_DO : M_DI;
        log_n <= log_n + 1;
        if (M_WE) begin
          res_v = 65'h0;
          case (off)
            8'h00: s_dvsr   <= M_DO;
            8'h08: s_dvcr   <= M_DO;
            8'h10: s_dvdnth <= M_DO;
            8'h04, 8'h14: begin
              res_v = divide((off == 8'h04) ? {{32{M_DO[31]}}, M_DO} : {s_dvdnth, M_DO}, s_dvsr);
              s_dvdntl  <= res_v[31:0];
              s_dvdnth  <= res_v[63:32];
              s_dvcr[0] <= res_v[64];
              stall_cnt <= 3;
            end
            default: ;
          endcase
        end
      end
    end
  end

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else
      $display("ok   %s: %h", tag, got);
  endtask

  task automatic set_req(input bit id, input bit v, input bit d64,
                         input logic [31:0] dvsr, input logic [31:0] h, input logic [31:0] l);
    if (!id) begin R0_REQ = v; R0_DIV64 = d64; R0_DVSR = dvsr; R0_DVDNTH = h; R0_DVDNTL = l; end
    else     begin R1_REQ = v; R1_DIV64 = d64; R1_DVSR = dvsr; R1_DVDNTH = h; R1_DVDNTL = l; end
  endtask

  task automatic wait_any(output bit ok, output bit id);
    ok = 0; id = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (R0_ACK || R1_ACK) begin ok = 1; id = R1_ACK; break; end
    end
  endtask

  task automatic check_acc(input string tag, input int idx, input logic [7:0] o, input bit we,
                           input logic [31:0] d, input bit chk_d);
    check(tag, {23'h0, log_we[idx[5:0]], log_off[idx[5:0]]}, {23'h0, we, o});
    if (chk_d) check({tag, "_data"}, log_d[idx[5:0]], d);
  endtask

  // Runs one job to its ACK (REQ dropped on the ACK cycle) and checks results.
  task automatic run_job(input string tag, input bit id, input bit d64, input logic [31:0] dvsr,
                         input logic [31:0] h, input logic [31:0] l, input logic [31:0] eq,
                         input logic [31:0] er, input bit eovf, input int nacc, output int base);
    bit ok, aid;
    base = log_n;
    set_req(id, 1'b1, d64, dvsr, h, l);
    wait_any(ok, aid);
    set_req(id, 1'b0, d64, dvsr, h, l);
    check({tag, "_ack_seen"}, 32'(ok), 32'd1);
    check({tag, "_ack_id"}, 32'(aid), 32'(id));
    check({tag, "_res_id"}, 32'(RES_ID), 32'(id));
    check({tag, "_res_q"}, RES_Q, eq);
    if (!eovf) check({tag, "_res_r"}, RES_R, er);
    check({tag, "_res_ovf"}, 32'(RES_OVF), 32'(eovf));
    check({tag, "_n_access"}, 32'(log_n - base), 32'(nacc));
  endtask

  initial begin : main
    int b, a0, a1, cnt0, cnt1;
    bit ok, id, stable;
    logic [31:0] ca, cd;
    logic cw;

    repeat (3) @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    check("rst_m_req", 32'(M_REQ), 32'd0);
    check("rst_m_we", 32'(M_WE), 32'd0);
    check("rst_m_a", M_A, BASE);
    check("rst_m_do", M_DO, 32'h0);
    check("rst_m_ba", 32'(M_BA), 32'hF);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_acks", {30'h0, R1_ACK, R0_ACK}, 32'h0);
    check("rst_res_q", RES_Q, 32'h0);

    // 32-bit job on R0: 100 / 7
    a0 = ack0_cnt;
    run_job("div32", 1'b0, 1'b0, 32'd7, 32'hDEAD, 32'd100, 32'd14, 32'd2, 1'b0, 5, b);
    check_acc("div32_acc0", b + 0, 8'h00, 1'b1, 32'd7, 1'b1);
    check_acc("div32_acc1", b + 1, 8'h04, 1'b1, 32'd100, 1'b1);
    check_acc("div32_acc2", b + 2, 8'h08, 1'b0, 32'h0, 1'b0);
    check_acc("div32_acc3", b + 3, 8'h14, 1'b0, 32'h0, 1'b0);
    check_acc("div32_acc4", b + 4, 8'h10, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge CLK);
    check("div32_ack_count", 32'(ack0_cnt - a0), 32'd1);

    // 64-bit job on R1: 0x1_00000000 / 0x10
    a1 = ack1_cnt;
    run_job("div64", 1'b1, 1'b1, 32'h10, 32'h1, 32'h0, 32'h10000000, 32'h0, 1'b0, 6, b);
    check_acc("div64_acc0", b + 0, 8'h00, 1'b1, 32'h10, 1'b1);
    check_acc("div64_acc1", b + 1, 8'h10, 1'b1, 32'h1, 1'b1);
    check_acc("div64_acc2", b + 2, 8'h14, 1'b1, 32'h0, 1'b1);
    check_acc("div64_acc3", b + 3, 8'h08, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge CLK);
    check("div64_ack_count", 32'(ack1_cnt - a1), 32'd1);

    // Divide by zero: OVF returned, DVCR cleared, ACK frozen while CE_R is low
    a0 = ack0_cnt;
    run_job("div0", 1'b0, 1'b0, 32'd0, 32'h0, 32'd5, 32'h7FFFFFFF, 32'h0, 1'b1, 6, b);
    check_acc("div0_clr_ovf", b + 5, 8'h08, 1'b1, 32'h0, 1'b1);
    CE_R = 0;
    repeat (3) @(negedge CLK);
    check("ce_freeze_ack", 32'(R0_ACK), 32'd1);
    check("ce_freeze_busy", 32'(BUSY), 32'd1);
    CE_R = 1;
    @(negedge CLK);
    check("ce_release_ack", 32'(R0_ACK), 32'd0);
    repeat (2) @(negedge CLK);
    check("div0_ack_count", 32'(ack0_cnt - a0), 32'd1);

    // Round robin after reset: both held for four jobs
    RST = 1; @(negedge CLK); RST = 0;
    set_req(1'b0, 1'b1, 1'b0, 32'd3, 32'h0, 32'd30);
    set_req(1'b1, 1'b1, 1'b0, 32'd5, 32'h0, 32'd27);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(ok, id);
      check($sformatf("arb%0d_ack_seen", k), 32'(ok), 32'd1);
      check($sformatf("arb%0d_order", k), 32'(id), 32'(k % 2));
      check($sformatf("arb%0d_res_id", k), 32'(RES_ID), 32'(id));
      check($sformatf("arb%0d_res_q", k), RES_Q, id ? 32'd5 : 32'd10);
      check($sformatf("arb%0d_res_r", k), RES_R, id ? 32'd2 : 32'd0);
      if (!id) begin cnt0++; if (cnt0 == 2) R0_REQ = 0; end
      else     begin cnt1++; if (cnt1 == 2) R1_REQ = 0; end
    end
    R0_REQ = 0; R1_REQ = 0;
    repeat (3) @(negedge CLK);

    // Bus stalls in WR_DVSR and RD_DVCR: 50 / 9
    b = log_n;
    busy_force = 1;
    set_req(1'b0, 1'b1, 1'b0, 32'd9, 32'h0, 32'd50);
    @(negedge CLK);
    ca = M_A; cd = M_DO; cw = M_WE; stable = M_REQ;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (M_A !== ca || M_DO !== cd || M_WE !== cw || !M_REQ) stable = 0;
    end
    check("stall_dvsr_stable", 32'(stable), 32'd1);
    check("stall_dvsr_addr", ca, BASE);
    check("stall_dvsr_data", cd, 32'd9);
    check("stall_dvsr_no_xfer", 32'(log_n - b), 32'd0);
    busy_force = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (M_REQ && !M_WE && M_A == BASE + 32'h08) begin ok = 1; break; end
    end
    check("stall_dvcr_reached", 32'(ok), 32'd1);
    busy_force = 1;
    ca = M_A; cw = M_WE; stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (M_A !== ca || M_WE !== cw || !M_REQ) stable = 0;
    end
    check("stall_dvcr_stable", 32'(stable), 32'd1);
    busy_force = 0;
    wait_any(ok, id);
    R0_REQ = 0;
    check("stall_ack_seen", 32'(ok), 32'd1);
    check("stall_res_q", RES_Q, 32'd5);
    check("stall_res_r", RES_R, 32'd5);
    check("stall_n_access", 32'(log_n - b), 32'd5);
    repeat (3) @(negedge CLK);

    // Reset pulsed while in RD_Q
    set_req(1'b0, 1'b1, 1'b0, 32'd7, 32'h0, 32'd100);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (M_REQ && !M_WE && M_A == BASE + 32'h14) begin ok = 1; break; end
    end
    check("rstjob_rd_q_reached", 32'(ok), 32'd1);
    RST = 1; R0_REQ = 0;
    @(negedge CLK);
    RST = 0;
    check("rstjob_m_req", 32'(M_REQ), 32'd0);
    check("rstjob_busy", 32'(BUSY), 32'd0);
    a0 = ack0_cnt;
    repeat (8) @(negedge CLK);
    check("rstjob_no_ack", 32'(ack0_cnt - a0), 32'd0);
    set_req(1'b0, 1'b1, 1'b0, 32'd4, 32'h0, 32'd40);
    set_req(1'b1, 1'b1, 1'b0, 32'd6, 32'h0, 32'd45);
    wait_any(ok, id);
    R0_REQ = 0;
    check("rstjob_ptr_first", 32'(id), 32'd0);
    check("rstjob_r0_q", RES_Q, 32'd10);
    wait_any(ok, id);
    R1_REQ = 0;
    check("rstjob_r1_ack", 32'(ok & id), 32'd1);
    check("rstjob_r1_res_id", 32'(RES_ID), 32'd1);
    check("rstjob_r1_q", RES_Q, 32'd7);
    check("rstjob_r1_r", RES_R, 32'd3);
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
